// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA output path: standard mode timings,
// the 0x00RRGGBB pixel field offsets and the blanked-address marker.
package vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_mode_t;

    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam vga_mode_t MODE_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23
    };

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    // Field offsets inside a 0x00RRGGBB pixel word
    localparam int RGB_R_LSB = 16;
    localparam int RGB_G_LSB = 8;
    localparam int RGB_B_LSB = 0;

    // Never inside any framebuffer, so the downstream range check drops the read
    localparam logic [9:0] ADDR_INVALID = 10'h3FF;

    function automatic int mode_h_total(input vga_mode_t m);
        return m.h_active + m.h_fp + m.h_sync + m.h_bp;
    endfunction

    function automatic int mode_v_total(input vga_mode_t m);
        return m.v_active + m.v_fp + m.v_sync + m.v_bp;
    endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// vga_sync_pipe
// Fixed-depth shift register that delays the raster flags so they line up
// with pixel data coming back from the framebuffer.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, loads RST_VAL into every stage
//   d       in   WIDTH  flags from the counter stage
//   q_prev  out  WIDTH  stage DEPTH-1 (one cycle ahead of q)
//   q       out  WIDTH  stage DEPTH
module vga_sync_pipe #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_prev,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q_prev = r_stage[DEPTH-2];
    assign q      = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Raster timing generator and pixel output stage, single vga_clk domain.
// Counters produce framebuffer addresses one cycle later; the framebuffer
// answers DATA_LAT cycles after that, and sync/blank are delayed to match so
// everything reaches the pins DATA_LAT+2 cycles after the counter position.
// Ports:
//   vga_clk      in   pixel clock
//   vga_rst      in   synchronous active-high reset
//   vga_h_addr   out  10  framebuffer column, ADDR_INVALID while blanked
//   vga_v_addr   out  10  framebuffer row, ADDR_INVALID while blanked
//   vga_data     in   32  pixel 0x00RRGGBB, top byte ignored
//   vga_hsync    out  horizontal sync
//   vga_vsync    out  vertical sync
//   vga_blank_n  out  1 = active video on the pins
//   vga_r/g/b    out  8   colour
//   frame_start  out  one-cycle pulse while pixel (0,0) is on the pins
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = MODE_800X600_72.h_active,
    parameter int H_FP        = MODE_800X600_72.h_fp,
    parameter int H_SYNC      = MODE_800X600_72.h_sync,
    parameter int H_BP        = MODE_800X600_72.h_bp,
    parameter int V_ACTIVE    = MODE_800X600_72.v_active,
    parameter int V_FP        = MODE_800X600_72.v_fp,
    parameter int V_SYNC      = MODE_800X600_72.v_sync,
    parameter int V_BP        = MODE_800X600_72.v_bp,
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b1,
    parameter int SCALE_SHIFT = 1,
    parameter int DATA_LAT    = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    output logic [9:0]  vga_h_addr,
    output logic [9:0]  vga_v_addr,
    input  logic [31:0] vga_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIPE_DEPTH = DATA_LAT + 2;

    localparam logic [10:0] LP_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] LP_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] LP_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] LP_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  LP_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LP_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  LP_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  LP_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Pipe flag layout: {sof, vsync level, hsync level, active}
    localparam logic [3:0]  LP_PIPE_RST   = {1'b0, ~VSYNC_POL, ~HSYNC_POL, 1'b0};

    logic [10:0] r_hcnt;
    logic [9:0]  r_vcnt;

    logic        w_active;
    logic        w_hs_lvl;
    logic        w_vs_lvl;
    logic        w_sof;
    logic [9:0]  w_h_scaled;
    logic [9:0]  w_v_scaled;
    logic [3:0]  w_pipe_in;
    logic [3:0]  w_pipe_prev;
    logic [3:0]  w_pipe_last;
    logic        w_unused_bits;

    // Stage 0: raster counters
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == LP_H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == LP_V_LAST) ? '0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 11'd1;
        end
    end

    assign w_active   = (r_hcnt < LP_H_ACT) && (r_vcnt < LP_V_ACT);
    assign w_hs_lvl   = ((r_hcnt >= LP_HS_START) && (r_hcnt < LP_HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign w_vs_lvl   = ((r_vcnt >= LP_VS_START) && (r_vcnt < LP_VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    assign w_sof      = (r_hcnt == 11'd0) && (r_vcnt == 10'd0);
    assign w_h_scaled = 10'(r_hcnt >> SCALE_SHIFT);
    assign w_v_scaled = 10'(r_vcnt >> SCALE_SHIFT);
    assign w_pipe_in  = {w_sof, w_vs_lvl, w_hs_lvl, w_active};

    // Stage 1: framebuffer address
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            vga_h_addr <= ADDR_INVALID;
            vga_v_addr <= ADDR_INVALID;
        end else begin
            vga_h_addr <= w_active ? w_h_scaled : ADDR_INVALID;
            vga_v_addr <= w_active ? w_v_scaled : ADDR_INVALID;
        end
    end

    vga_sync_pipe #(
        .WIDTH   (4),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL (LP_PIPE_RST)
    ) u_sync_pipe (
        .clk    (vga_clk),
        .rst    (vga_rst),
        .d      (w_pipe_in),
        .q_prev (w_pipe_prev),
        .q      (w_pipe_last)
    );

    // Stage DATA_LAT+2: colour is registered in the same edge that moves the
    // flags into the last pipe stage, so it gates on the previous-stage active bit.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (w_pipe_prev[0]) begin
            vga_r <= vga_data[RGB_R_LSB +: 8];
            vga_g <= vga_data[RGB_G_LSB +: 8];
            vga_b <= vga_data[RGB_B_LSB +: 8];
        end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end
    end

    assign vga_blank_n = w_pipe_last[0];
    assign vga_hsync   = w_pipe_last[1];
    assign vga_vsync   = w_pipe_last[2];
    assign frame_start = w_pipe_last[3];

    // Alpha byte and the early copies of the sync flags are intentionally unused
    assign w_unused_bits = ^{vga_data[31:24], w_pipe_prev[3:1]};

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: default 800x600 mode, DATA_LAT=1. B: tiny mode, DATA_LAT=3, hsync active-low.
    logic        rstA, rstB;
    logic [9:0]  hA, vA, hB, vB;
    logic [31:0] dA, dB;
    logic        hsA, vsA, bnA, fsA, hsB, vsB, bnB, fsB;
    logic [7:0]  rA, gA, bA, rB, gB, bB;

    vga_timing_ctrl u_dut_a (
        .vga_clk(clk), .vga_rst(rstA), .vga_h_addr(hA), .vga_v_addr(vA),
        .vga_data(dA), .vga_hsync(hsA), .vga_vsync(vsA), .vga_blank_n(bnA),
        .vga_r(rA), .vga_g(gA), .vga_b(bA), .frame_start(fsA)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SCALE_SHIFT(1), .DATA_LAT(3)
    ) u_dut_b (
        .vga_clk(clk), .vga_rst(rstB), .vga_h_addr(hB), .vga_v_addr(vB),
        .vga_data(dB), .vga_hsync(hsB), .vga_vsync(vsB), .vga_blank_n(bnB),
        .vga_r(rB), .vga_g(gB), .vga_b(bB), .frame_start(fsB)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Framebuffer contents as seen by the bench
    function automatic logic [23:0] pix(input logic [9:0] ha, input logic [9:0] va);
        return 24'(int'(ha) * 32'h010203 + int'(va) * 32'h040000);
    endfunction

    typedef struct {
        int ha, va, hs, vs, bn, fs, r, g, b;
    } exp_t;

    // k = counting edges since the last reset edge; the counter sits at raster
    // position k, addresses show position k-1, pins show position k-lat-2.
    function automatic exp_t model(input int k, input int ha_, input int hfp, input int hsw, input int hbp,
                                   input int va_, input int vfp, input int vsw, input int vbp,
                                   input int lat, input int sh, input int hp, input int vp);
        exp_t e;
        int ht = ha_ + hfp + hsw + hbp;
        int vt = va_ + vfp + vsw + vbp;
        int p  = k - (lat + 2);
        int q  = k - 1;
        int h, v;
        logic [23:0] px;
        e.ha = 'h3FF; e.va = 'h3FF;
        if (q >= 0) begin
            h = q % ht; v = (q / ht) % vt;
            if (h < ha_ && v < va_) begin
                e.ha = h >> sh; e.va = v >> sh;
            end
        end
        e.hs = 1 - hp; e.vs = 1 - vp; e.bn = 0; e.fs = 0; e.r = 0; e.g = 0; e.b = 0;
        if (p >= 0) begin
            h = p % ht; v = (p / ht) % vt;
            e.bn = (h < ha_ && v < va_) ? 1 : 0;
            if (h >= ha_ + hfp && h < ha_ + hfp + hsw) e.hs = hp;
            if (v >= va_ + vfp && v < va_ + vfp + vsw) e.vs = vp;
            e.fs = (h == 0 && v == 0) ? 1 : 0;
            if (e.bn == 1) begin
                px = pix(10'(h >> sh), 10'(v >> sh));
                e.r = px[23:16]; e.g = px[15:8]; e.b = px[7:0];
            end
        end
        return e;
    endfunction

    // Position trackers
    int kA = -1, kB = -1;
    always @(posedge clk) begin
        if (rstA) kA = 0; else if (kA >= 0) kA++;
        if (rstB) kB = 0; else if (kB >= 0) kB++;
    end

    // Framebuffer models: data for an address appears DATA_LAT cycles after it
    logic [9:0] hA_hist = 10'h3FF, vA_hist = 10'h3FF;
    logic [9:0] hB_hist [3] = '{10'h3FF, 10'h3FF, 10'h3FF};
    logic [9:0] vB_hist [3] = '{10'h3FF, 10'h3FF, 10'h3FF};
    initial begin dA = '0; dB = '0; end
    always @(posedge clk) begin
        #1;
        dA = {8'hFF, pix(hA_hist, vA_hist)};
        hA_hist = hA; vA_hist = vA;
        dB = {8'hFF, pix(hB_hist[2], vB_hist[2])};
        hB_hist[2] = hB_hist[1]; hB_hist[1] = hB_hist[0]; hB_hist[0] = hB;
        vB_hist[2] = vB_hist[1]; vB_hist[1] = vB_hist[0]; vB_hist[0] = vB;
    end

    int fs_cnt_a = 0, fs_cnt_b = 0;
    int hs_rise_a = -1, vs_rise_b = -1;
    logic hs_prev_a = 1'b0, vs_prev_b = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (kA >= 0) begin
            e = model(kA, 800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 1, 1);
            chk("A_h_addr", hA, e.ha);   chk("A_v_addr", vA, e.va);
            chk("A_hsync", hsA, e.hs);   chk("A_vsync", vsA, e.vs);
            chk("A_blank_n", bnA, e.bn); chk("A_frame_start", fsA, e.fs);
            chk("A_r", rA, e.r); chk("A_g", gA, e.g); chk("A_b", bA, e.b);
            if (fsA === 1'b1) fs_cnt_a++;
            // Hand-computed anchors
            if (kA == 1)    chk("A_lit_h_addr_c0", hA, 0);
            if (kA == 3)    chk("A_lit_h_addr_c2", hA, 1);
            if (kA == 800)  chk("A_lit_h_addr_c799", hA, 399);
            if (kA == 801)  chk("A_lit_h_addr_c800", hA, 'h3FF);
            if (kA == 1041) chk("A_lit_v_addr_line1", vA, 0);
            if (kA == 2081) chk("A_lit_v_addr_line2", vA, 1);
            if (kA == 2)    chk("A_lit_fs_early", fsA, 0);
            if (kA == 3)    chk("A_lit_fs", fsA, 1);
            if (kA == 7)    chk("A_lit_blank_c4", bnA, 1);
            if (kA == 8) begin
                chk("A_lit_blank_px5", bnA, 1);
                chk("A_lit_r_px5", rA, 2); chk("A_lit_g_px5", gA, 4); chk("A_lit_b_px5", bA, 6);
            end
            if (kA == 858)  chk("A_lit_hsync_pre", hsA, 0);
            if (kA == 859)  chk("A_lit_hsync_start", hsA, 1);
            // hsync period/width
            if (kA == 0) hs_rise_a = -1;
            if (hsA === 1'b1 && hs_prev_a === 1'b0) begin
                if (hs_rise_a >= 0) chk("A_hsync_period", kA - hs_rise_a, 1040);
                hs_rise_a = kA;
            end
            if (hsA === 1'b0 && hs_prev_a === 1'b1 && hs_rise_a >= 0)
                chk("A_hsync_width", kA - hs_rise_a, 120);
            hs_prev_a = hsA;
        end
        if (kB >= 0) begin
            e = model(kB, 16, 4, 6, 6, 10, 2, 3, 3, 3, 1, 0, 1);
            chk("B_h_addr", hB, e.ha);   chk("B_v_addr", vB, e.va);
            chk("B_hsync", hsB, e.hs);   chk("B_vsync", vsB, e.vs);
            chk("B_blank_n", bnB, e.bn); chk("B_frame_start", fsB, e.fs);
            chk("B_r", rB, e.r); chk("B_g", gB, e.g); chk("B_b", bB, e.b);
            if (fsB === 1'b1) fs_cnt_b++;
            if (kB == 4)   chk("B_lit_fs_early", fsB, 0);
            if (kB == 5)   chk("B_lit_fs", fsB, 1);
            if (kB == 388) chk("B_lit_vsync_pre", vsB, 0);
            if (kB == 389) chk("B_lit_vsync_start", vsB, 1);
            if (kB == 5)   chk("B_lit_hsync_idle", hsB, 1);
            if (kB == 0) vs_rise_b = -1;
            if (vsB === 1'b1 && vs_prev_b === 1'b0) begin
                if (vs_rise_b >= 0) chk("B_vsync_period", kB - vs_rise_b, 576);
                vs_rise_b = kB;
            end
            if (vsB === 1'b0 && vs_prev_b === 1'b1 && vs_rise_b >= 0)
                chk("B_vsync_width", kB - vs_rise_b, 96);
            vs_prev_b = vsB;
        end
    end

    // Reset 10 cycles, then mid-frame reset pulses (A near hcnt=500 of line 2)
    int cyc = 0;
    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        while (cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            rstA = (cyc < 10) || (cyc >= 2590 && cyc < 2592);
            rstB = (cyc < 10) || (cyc >= 1310 && cyc < 1312);
        end
        @(negedge clk);
        #1;
        chk("A_frame_start_count", fs_cnt_a, 2);
        chk("B_frame_start_count", fs_cnt_b, 10);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
